// File: rtl/ocarina_pkg.sv
// Shared definitions for the ocarina audio path: note player FSM states,
// default tone-divider width and note half-periods for a 50 MHz clock.
package ocarina_pkg;

  localparam int DIV_W = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Half-period in clk cycles = 50e6 / (2 * f_note)
  localparam logic [DIV_W-1:0] REST = '0;

  localparam logic [DIV_W-1:0] C4  = 26'd95_556;
  localparam logic [DIV_W-1:0] CS4 = 26'd90_193;
  localparam logic [DIV_W-1:0] D4  = 26'd85_131;
  localparam logic [DIV_W-1:0] DS4 = 26'd80_353;
  localparam logic [DIV_W-1:0] E4  = 26'd75_843;
  localparam logic [DIV_W-1:0] F4  = 26'd71_586;
  localparam logic [DIV_W-1:0] FS4 = 26'd67_568;
  localparam logic [DIV_W-1:0] G4  = 26'd63_776;
  localparam logic [DIV_W-1:0] GS4 = 26'd60_196;
  localparam logic [DIV_W-1:0] A4  = 26'd56_818;
  localparam logic [DIV_W-1:0] AS4 = 26'd53_629;
  localparam logic [DIV_W-1:0] B4  = 26'd50_619;

  localparam logic [DIV_W-1:0] C5  = 26'd47_778;
  localparam logic [DIV_W-1:0] CS5 = 26'd45_097;
  localparam logic [DIV_W-1:0] D5  = 26'd42_565;
  localparam logic [DIV_W-1:0] DS5 = 26'd40_177;
  localparam logic [DIV_W-1:0] E5  = 26'd37_922;
  localparam logic [DIV_W-1:0] F5  = 26'd35_793;
  localparam logic [DIV_W-1:0] FS5 = 26'd33_784;
  localparam logic [DIV_W-1:0] G5  = 26'd31_888;
  localparam logic [DIV_W-1:0] GS5 = 26'd30_098;
  localparam logic [DIV_W-1:0] A5  = 26'd28_409;
  localparam logic [DIV_W-1:0] AS5 = 26'd26_815;
  localparam logic [DIV_W-1:0] B5  = 26'd25_310;

endpackage

// File: rtl/tone_divider.sv
// Reloading down-counter that toggles a square-wave output every `period`
// enabled cycles. `load` primes the counter for a new note with the output
// low; `clr` silences the output and parks the counter.
module tone_divider #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [DIV_W-1:0] load_period,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tone
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;

  // Counting from P-1 down to 0 gives exactly P cycles between toggles.
  function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] p);
    return (p == '0) ? '0 : p - ONE;
  endfunction

  // Tone counter and square-wave output register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (load) begin
      cnt  <= reload_val(load_period);
      tone <= 1'b0;
    end else if (en) begin
      if (cnt == '0) begin
        tone <= ~tone;
        cnt  <= reload_val(period);
      end else begin
        cnt <= cnt - ONE;
      end
    end
  end

endmodule

// File: rtl/note_player.sv
// Plays one note at a time: accepts a half-period from the sequencer, drives
// the tone for NOTE_CYCLES, then holds silence for GAP_CYCLES before
// signalling completion. Rest notes (half-period 0) play silence.
module note_player
  import ocarina_pkg::*;
#(
  parameter int NOTE_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int DIV_W       = ocarina_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] clkdivider,
  input  logic             note_valid,
  output logic             note_ready,
  output logic             audio_out,
  output logic             note_done,
  output logic             busy
);

  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0] NOTE_LAST = DIV_W'(NOTE_CYCLES - 1);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  logic [DIV_W-1:0] dur_cnt;
  logic [DIV_W-1:0] period_q;
  logic             accept;
  logic             play_end;
  logic             tone_en;

  // Note_ready is registered high exactly in IDLE, so valid alone qualifies.
  assign accept   = (state == ST_IDLE) && note_valid;
  assign play_end = (state == ST_PLAY) && (dur_cnt == '0);
  assign tone_en  = (state == ST_PLAY) && (period_q != '0);

  // Note FSM with duration/gap timing and registered handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      dur_cnt    <= '0;
      period_q   <= '0;
      note_ready <= 1'b1;
      busy       <= 1'b0;
      note_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          note_done <= 1'b0;
          if (note_valid) begin
            period_q   <= clkdivider;
            dur_cnt    <= NOTE_LAST;
            state      <= ST_PLAY;
            note_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (dur_cnt == '0) begin
            if (GAP_CYCLES == 0) begin
              state      <= ST_IDLE;
              note_done  <= 1'b1;
              note_ready <= 1'b1;
              busy       <= 1'b0;
            end else begin
              state   <= ST_GAP;
              dur_cnt <= GAP_LAST;
            end
          end else begin
            dur_cnt <= dur_cnt - ONE;
          end
        end
        ST_GAP: begin
          if (dur_cnt == '0) begin
            state      <= ST_IDLE;
            note_done  <= 1'b1;
            note_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            dur_cnt <= dur_cnt - ONE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          note_ready <= 1'b1;
          busy       <= 1'b0;
          note_done  <= 1'b0;
        end
      endcase
    end
  end

  tone_divider #(
    .DIV_W(DIV_W)
  ) u_tone (
    .clk        (clk),
    .resetn     (resetn),
    .load       (accept),
    .load_period(clkdivider),
    .en         (tone_en),
    .clr        (play_end),
    .period     (period_q),
    .tone       (audio_out)
  );

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: two instances (gap of 4 cycles and no gap) driven
// by directed and random notes; a cycle-level reference of the note timing
// rules predicts every output, and a per-note scoreboard is settled on each
// note_done pulse.
module tb_note_player;

  localparam int NC = 20;
  localparam int DW = 26;

  typedef struct {
    int p;
    int done_cyc;
    int busy_n;
    int hi_n;
    int tr_n;
    int spec_tog;
  } note_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] div  [2];
  logic          vld  [2];
  logic          rdy  [2];
  logic          aud  [2];
  logic          done [2];
  logic          busy [2];

  always #5 clk = ~clk;

  note_player #(.NOTE_CYCLES(NC), .GAP_CYCLES(4), .DIV_W(DW)) u_dut0 (
    .clk(clk), .resetn(resetn), .clkdivider(div[0]), .note_valid(vld[0]),
    .note_ready(rdy[0]), .audio_out(aud[0]), .note_done(done[0]), .busy(busy[0]));

  note_player #(.NOTE_CYCLES(NC), .GAP_CYCLES(0), .DIV_W(DW)) u_dut1 (
    .clk(clk), .resetn(resetn), .clkdivider(div[1]), .note_valid(vld[1]),
    .note_ready(rdy[1]), .audio_out(aud[1]), .note_done(done[1]), .busy(busy[1]));

  // ---------------- reference model ----------------
  note_t sbq [2][$];
  int    cyc = 0;
  bit    m_act  [2];
  int    m_acc  [2];
  int    m_p    [2];
  int    m_done [2];
  int    m_nacc [2];
  int    spec_tog [2];

  function automatic int gap_of(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  // Tone level t cycles after accept: toggles at P, 2P, ... while t < NC.
  function automatic bit wave(input int t, input int p);
    if (p == 0 || t < 1 || t >= NC) return 1'b0;
    return ((t / p) % 2) == 1;
  endfunction

  function automatic note_t expect_note(input int p, input int acc, input int g);
    note_t e;
    bit prev, w;
    e.p = p; e.done_cyc = acc + NC + g; e.busy_n = NC + g;
    e.hi_n = 0; e.tr_n = 0; e.spec_tog = -1;
    prev = 1'b0;
    for (int t = 0; t <= NC + g; t++) begin
      w = wave(t, p);
      if (t < NC + g && w) e.hi_n++;
      if (w != prev) e.tr_n++;
      prev = w;
    end
    return e;
  endfunction

  initial begin
    note_t e;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_acc[i] = 0; m_p[i] = 0; m_done[i] = -1; m_nacc[i] = 0;
    end
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        for (int i = 0; i < 2; i++) begin
          m_act[i] = 1'b0; m_done[i] = -1;
        end
      end else begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
          if (m_act[i]) begin
            if (cyc - m_acc[i] == NC + gap_of(i)) begin
              m_act[i] = 1'b0; m_done[i] = cyc;
            end
          end else if (vld[i]) begin
            m_act[i] = 1'b1; m_acc[i] = cyc; m_p[i] = int'(div[i]); m_nacc[i]++;
            e = expect_note(m_p[i], cyc, gap_of(i));
            e.spec_tog = spec_tog[i];
            sbq[i].push_back(e);
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int n_chk = 0;
  int n_fail = 0;
  int o_busy [2];
  int o_hi   [2];
  int o_tr   [2];
  bit o_prev [2];
  bit end_req = 1'b0;
  bit end_ack = 1'b0;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got %0d expected %0d", nm, i, cyc, act, exp);
    end
  endtask

  initial begin
    note_t e;
    bit ea, eb, er, ed;
    int t;
    for (int i = 0; i < 2; i++) begin
      o_busy[i] = 0; o_hi[i] = 0; o_tr[i] = 0; o_prev[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!resetn) begin
          chk("rst_audio", i, int'(aud[i]), 0);
          chk("rst_ready", i, int'(rdy[i]), 1);
          chk("rst_busy",  i, int'(busy[i]), 0);
          chk("rst_done",  i, int'(done[i]), 0);
          sbq[i].delete();
          o_busy[i] = 0; o_hi[i] = 0; o_tr[i] = 0; o_prev[i] = 1'b0;
        end else begin
          if (m_act[i]) begin
            t = cyc - m_acc[i];
            ea = wave(t, m_p[i]); eb = 1'b1; er = 1'b0; ed = 1'b0;
          end else begin
            ea = 1'b0; eb = 1'b0; er = 1'b1; ed = (cyc == m_done[i]);
          end
          chk("audio", i, int'(aud[i]), int'(ea));
          chk("busy",  i, int'(busy[i]), int'(eb));
          chk("ready", i, int'(rdy[i]), int'(er));
          chk("done",  i, int'(done[i]), int'(ed));
          if (aud[i] != o_prev[i]) o_tr[i]++;
          o_prev[i] = aud[i];
          if (busy[i]) begin
            o_busy[i]++;
            if (aud[i]) o_hi[i]++;
          end
          if (done[i]) begin
            if (sbq[i].size() == 0) begin
              chk("done_unexpected", i, int'(done[i]), 0);
            end else begin
              e = sbq[i].pop_front();
              chk("note_done_cycle", i, cyc, e.done_cyc);
              chk("note_busy_len",   i, o_busy[i], e.busy_n);
              chk("note_high_cyc",   i, o_hi[i], e.hi_n);
              chk("note_toggles",    i, o_tr[i], e.tr_n);
              if (e.spec_tog >= 0) chk("spec_toggles", i, o_tr[i], e.spec_tog);
            end
            o_busy[i] = 0; o_hi[i] = 0; o_tr[i] = 0;
          end
        end
      end
      if (end_req && !end_ack) begin
        for (int i = 0; i < 2; i++) chk("sb_drained", i, sbq[i].size(), 0);
        end_ack = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i);
    int g = 0;
    while (m_act[i] && g < 2000) begin tick(); g++; end
  endtask

  task automatic send(input int i, input int p, input int st);
    wait_idle(i);
    div[i] = DW'(p);
    spec_tog[i] = st;
    vld[i] = 1'b1;
    tick();
    vld[i] = 1'b0;
    spec_tog[i] = -1;
  endtask

  task automatic wait_accept(input int i, input int n0);
    int g = 0;
    while (m_nacc[i] == n0 && g < 200) begin tick(); g++; end
  endtask

  task automatic rand_run(input int i, input int n);
    int r, p;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      r = $urandom_range(0, 9);
      if (r == 0)      p = 0;
      else if (r == 1) p = 1;
      else if (r == 2) p = $urandom_range(21, 100);
      else if (r == 3) p = 67_108_863;
      else             p = $urandom_range(2, 20);
      send(i, p, -1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 10)) tick();
        if (m_act[i]) begin
          div[i] = DW'($urandom_range(0, 30));
          vld[i] = 1'b1;
          tick();
          vld[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int n0, g;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; div[i] = '0; spec_tog[i] = -1;
    end
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;

    // first note right after reset release, then rest, clk/2, too-long period
    send(0, 5, 4);   wait_idle(0); tick();
    send(0, 0, 0);   wait_idle(0);
    send(0, 1, 20);  wait_idle(0);
    send(0, 25, 0);  wait_idle(0); tick(); tick();

    // valid held high, no gap: 5, 3, rest back to back
    vld[1] = 1'b1;
    div[1] = DW'(5); spec_tog[1] = 4; n0 = m_nacc[1]; wait_accept(1, n0);
    div[1] = DW'(3); spec_tog[1] = 6; n0 = m_nacc[1]; wait_accept(1, n0);
    div[1] = DW'(0); spec_tog[1] = 0; n0 = m_nacc[1]; wait_accept(1, n0);
    vld[1] = 1'b0; spec_tog[1] = -1;
    wait_idle(1); tick();

    // valid pulsed and divider changed mid-PLAY
    send(0, 5, 4);
    repeat (7) tick();
    div[0] = DW'(3); vld[0] = 1'b1; tick(); vld[0] = 1'b0;
    repeat (3) tick();
    div[0] = DW'(7);
    wait_idle(0); tick();

    // reset in the middle of a note, then a fresh note
    send(0, 5, -1);
    repeat (11) tick();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    send(0, 5, 4);
    wait_idle(0); tick();

    fork
      rand_run(0, 25);
      rand_run(1, 25);
    join
    wait_idle(0); wait_idle(1);
    repeat (3) tick();

    end_req = 1'b1;
    g = 0;
    while (!end_ack && g < 10) begin tick(); g++; end
    if (!end_ack) begin
      $display("FAIL end_handshake got 0 expected 1");
      $fatal(1, "monitor did not respond");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog cyc=%0d got timeout expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
